// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48E1 slice through an N-term multiply-accumulate: issues operand
// addresses, aligns OPMODE/CEP to the product pipeline and captures the final P.
module dsp_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               abort,
  output logic               busy,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               op_valid,
  output logic [6:0]         opmode,
  output logic [3:0]         alumode,
  output logic               cep,
  input  logic signed [47:0] p_in,
  output logic signed [47:0] result,
  output logic               done
);

  localparam logic [6:0] OPM_IDLE = 7'h00;
  localparam logic [6:0] OPM_LOAD = 7'h05;
  localparam logic [6:0] OPM_ACC  = 7'h25;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic signed [47:0]    result_q, result_d;
  logic                  done_q, done_d;

  logic                  first_issue;
  logic                  last_term;
  logic                  tap_vld;
  logic                  tap_first;
  logic                  pipe_empty;

  assign first_issue = op_valid && (cnt_q == '0);
  assign last_term   = (cnt_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    result_d = result_q;
    done_d   = 1'b0;
    op_valid = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (len != '0) begin
            len_d   = len;
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            result_d = '0;
            done_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        op_valid = 1'b1;
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (last_term) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Once the last tag has left the shift register, its cep cycle is over
        // and p_in now carries the complete sum.
        if (abort) begin
          state_d = IDLE;
        end else if (pipe_empty) begin
          result_d = p_in;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (PIPE_LAT <= 1) begin : g_tap_direct
      assign tap_vld    = op_valid;
      assign tap_first  = first_issue;
      assign pipe_empty = 1'b1;
    end else begin : g_tap_shift
      localparam int DEPTH = PIPE_LAT - 1;
      logic [DEPTH-1:0] vld_pipe_q;
      logic [DEPTH-1:0] first_pipe_q;

      // ---- issue -> ALU alignment stages ----
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_pipe_q   <= '0;
          first_pipe_q <= '0;
        end else if (abort) begin
          vld_pipe_q   <= '0;
          first_pipe_q <= '0;
        end else begin
          vld_pipe_q   <= DEPTH'({vld_pipe_q, op_valid});
          first_pipe_q <= DEPTH'({first_pipe_q, first_issue});
        end
      end

      assign tap_vld    = vld_pipe_q[DEPTH-1];
      assign tap_first  = first_pipe_q[DEPTH-1];
      assign pipe_empty = (vld_pipe_q == '0);
    end
  endgenerate

  always_comb begin
    opmode = OPM_IDLE;
    if (tap_vld) begin
      opmode = tap_first ? OPM_LOAD : OPM_ACC;
    end
  end

  assign cep      = tap_vld;
  assign alumode  = 4'b0000;
  assign addr_out = ADDR_W'(cnt_q);
  assign result   = result_q;
  assign done     = done_q;

endmodule
